issue_scheduler: RTL and testbench

In-order issue controller that sits between the Decoder and the reg_rf stage register of the 5-stage 8-bit pipelined core. It tracks destination registers still in flight in a shift-register scoreboard. When a decoded instruction reads a register that has not yet been written back, the block stalls the front end and injects bubbles, so the unforwarded pipeline computes correct results. It also provides a drain handshake so software or the test harness can wait for the pipeline to empty.

---
 rtl/issue_scheduler_pkg.sv | 6 +
 rtl/scoreboard_shift.sv | 37 +++
 rtl/issue_scheduler.sv | 90 +++++++++
 tb/tb_issue_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared FSM state enum, default register-index width and control-field width
package issue_scheduler_pkg;
  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;
  localparam int RW_DEF = 4;
  localparam int CTRL_W = 4;
endpackage

// File: rtl/scoreboard_shift.sv
// scoreboard_shift: DEPTH-entry {v, rd} write tracker (entry DEPTH-1 is the write-back slot, excluded from matching) with two match ports and empty flag
module scoreboard_shift
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_v,
  input  logic [RW-1:0] load_rd,
  input  logic [RW-1:0] q1,
  input  logic [RW-1:0] q2,
  output logic          m1,
  output logic          m2,
  output logic          empty
);
  logic [DEPTH-1:0] v;
  logic [RW-1:0]    rd [DEPTH];
  always_ff @(posedge clk) begin
    v[0]  <= rst && load_v;
    rd[0] <= load_rd;
    for (int i = 1; i < DEPTH; i++) begin
      v[i]  <= rst && v[i-1];
      rd[i] <= rd[i-1];
    end
  end
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m1 = m1 | (v[i] && (i < DEPTH - 1) && rd[i] == q1);
      m2 = m2 | (v[i] && (i < DEPTH - 1) && rd[i] == q2);
    end
  end
  assign empty = ~|v;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue stage stalling on RAW hazards, drain handshake; ISSUE_STATS_EN adds stall_cnt/issue_cnt
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RW = RW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RW-1:0]     in_rd,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic              in_rs1_used,
  input  logic              in_rs2_used,
  input  logic              in_w,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              iss_valid,
  output logic              iss_w,
  output logic [RW-1:0]     iss_rd,
  output logic [RW-1:0]     iss_rs1,
  output logic [RW-1:0]     iss_rs2,
  output logic [CTRL_W-1:0] iss_ctrl,
  input  logic              drain_req,
  output logic              idle,
  output logic              stall
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       issue_cnt
`endif
);
  state_t state, state_n;
  logic   hazard, m1, m2, empty, accept;
  scoreboard_shift #(.DEPTH(DEPTH), .RW(RW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .load_v  (accept && in_w),
    .load_rd (in_rd),
    .q1      (in_rs1),
    .q2      (in_rs2),
    .m1      (m1),
    .m2      (m2),
    .empty   (empty)
  );
  assign hazard = (in_rs1_used && m1) || (in_rs2_used && m2);
  assign accept = rst && in_valid && in_ready;
  always_ff @(posedge clk) state <= !rst ? RUN : state_n;
  always_comb
    state_n = drain_req       ? DRAIN :
              state == DRAIN  ? RUN :
              state == RUN    ? ((hazard && in_valid) ? STALL : RUN) :
              hazard          ? STALL : RUN;
  always_comb begin
    in_ready = !rst || (state != DRAIN && !drain_req && !hazard);
    stall    = in_valid && !in_ready;
    idle     = state == DRAIN && empty;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      iss_valid <= 1'b0;
      iss_w     <= 1'b0;
      iss_rd    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_ctrl  <= '0;
    end else begin
      iss_valid <= accept;
      iss_w     <= accept && in_w;
      if (accept) begin
        iss_rd   <= in_rd;
        iss_rs1  <= in_rs1;
        iss_rs2  <= in_rs2;
        iss_ctrl <= in_ctrl;
      end
    end
  end
`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 16'(stall && stall_cnt != 16'hFFFF);
      issue_cnt <= issue_cnt + 16'(accept && issue_cnt != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and random stimulus against a cycle-stamp hazard model
module tb_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int RW = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_rs1_used = 1'b0, in_rs2_used = 1'b0, in_w = 1'b0;
  logic [RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [3:0] in_ctrl = '0;
  logic iss_valid, iss_w, drain_req = 1'b0, idle, stall;
  logic [RW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic [3:0] iss_ctrl;
`ifdef ISSUE_STATS_EN
  logic [15:0] stall_cnt, issue_cnt;
`endif
  always #5 clk = ~clk;
  issue_scheduler #(.DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_w(in_w), .in_ctrl(in_ctrl), .iss_valid(iss_valid), .iss_w(iss_w), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ctrl(iss_ctrl), .drain_req(drain_req),
    .idle(idle), .stall(stall)
`ifdef ISSUE_STATS_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );
  int checks = 0, failures = 0, n = 0, stalls = 0, acc_cyc = 0;
  int last [16];
  bit m_drain = 0, last_acc = 0, idle_seen;
  logic e_v = 0, e_w = 0;
  logic [3:0] e_rd = 0, e_rs1 = 0, e_rs2 = 0, e_ctrl = 0;
  int e_sc = 0, e_ic = 0, prod;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
    end
  endtask
  function automatic bit busy(input logic [3:0] r);
    return n - last[r] < DEPTH;
  endfunction
  function automatic bit sb_empty();
    for (int r = 0; r < 16; r++) if (n - last[r] <= DEPTH) return 0;
    return 1;
  endfunction
  task automatic tick();
    bit haz, er, acc;
    @(negedge clk);
    haz = (in_rs1_used && busy(in_rs1)) || (in_rs2_used && busy(in_rs2));
    er = !rst ? 1'b1 : (m_drain || drain_req) ? 1'b0 : !haz;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("stall", 32'(stall), 32'(in_valid && !er));
    chk("idle", 32'(idle), 32'(m_drain && sb_empty()));
    stalls += 32'(stall);
    if (idle) idle_seen = 1;
    acc = rst && in_valid && er;
    @(posedge clk);
    last_acc = acc;
    if (!rst) begin
      foreach (last[r]) last[r] = -1000;
      m_drain = 0; e_v = 0; e_w = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0; e_ctrl = 0; e_sc = 0; e_ic = 0;
    end else begin
      m_drain = drain_req;
      if (in_valid && !er && e_sc < 65535) e_sc++;
      if (acc && e_ic < 65535) e_ic++;
      e_v = acc;
      e_w = acc && in_w;
      if (acc) begin
        e_rd = in_rd; e_rs1 = in_rs1; e_rs2 = in_rs2; e_ctrl = in_ctrl;
        acc_cyc = n;
        if (in_w) last[in_rd] = n;
      end
    end
    n++;
    #1;
    chk("iss_valid", 32'(iss_valid), 32'(e_v));
    chk("iss_w", 32'(iss_w), 32'(e_w));
    chk("iss_rd", 32'(iss_rd), 32'(e_rd));
    chk("iss_rs1", 32'(iss_rs1), 32'(e_rs1));
    chk("iss_rs2", 32'(iss_rs2), 32'(e_rs2));
    chk("iss_ctrl", 32'(iss_ctrl), 32'(e_ctrl));
`ifdef ISSUE_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(e_sc));
    chk("issue_cnt", 32'(issue_cnt), 32'(e_ic));
`endif
  endtask
  task automatic pres(input bit v, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                      input bit u1, input bit u2, input bit w);
    in_valid = v; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_rs1_used = u1; in_rs2_used = u2; in_w = w; in_ctrl = 4'($urandom);
    tick();
  endtask
  task automatic do_reset();
    rst = 0;
    pres(1, 3, 3, 3, 1, 1, 1);
    rst = 1;
  endtask
  initial begin
    foreach (last[r]) last[r] = -1000;
    #1;
    do_reset();
    pres(0, 0, 0, 0, 0, 0, 0);
    stalls = 0;
    pres(1, 3, 1, 2, 1, 1, 1);
    prod = acc_cyc;
    for (int k = 0; k < 10; k++) begin
      pres(1, 5, 3, 0, 1, 0, 1);
      if (last_acc) break;
    end
    chk("raw_accepted", 32'(last_acc), 1);
    chk("raw_stalls", 32'(stalls), 3);
    chk("raw_gap", 32'(acc_cyc - prod), DEPTH);
`ifdef ISSUE_STATS_EN
    chk("raw_stall_cnt", 32'(stall_cnt), 3);
    chk("raw_issue_cnt", 32'(issue_cnt), 2);
`endif
    for (int k = 0; k < 6; k++) pres(0, 0, 0, 0, 0, 0, 0);
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      pres(1, 4'(1 + 3 * k), 4'(2 + 3 * k), 4'(3 + 3 * k), 1, 1, 1);
      chk("indep_acc", 32'(last_acc), 1);
    end
    chk("indep_stalls", 32'(stalls), 0);
    for (int k = 0; k < 6; k++) pres(0, 0, 0, 0, 0, 0, 0);
    pres(1, 7, 0, 0, 0, 0, 1);
    pres(1, 8, 1, 7, 1, 0, 1);
    chk("unused_src_acc", 32'(last_acc), 1);
    pres(1, 1, 0, 0, 0, 0, 1);
    pres(1, 2, 0, 0, 0, 0, 1);
    drain_req = 1;
    idle_seen = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      pres(1, 9, 0, 0, 0, 0, 1);
      chk("drain_no_acc", 32'(last_acc), 0);
    end
    chk("drain_idle_seen", 32'(idle_seen), 1);
    drain_req = 0;
    pres(1, 9, 0, 0, 0, 0, 1);
    chk("drain_exit_hold", 32'(last_acc), 0);
    pres(1, 9, 0, 0, 0, 0, 1);
    chk("drain_exit_acc", 32'(last_acc), 1);
    for (int k = 0; k < 6; k++) pres(0, 0, 0, 0, 0, 0, 0);
    pres(1, 3, 0, 0, 0, 0, 1);
    pres(1, 5, 3, 0, 1, 0, 1);
    chk("midstall_held", 32'(last_acc), 0);
    do_reset();
    stalls = 0;
    pres(1, 5, 3, 0, 1, 0, 1);
    chk("post_reset_acc", 32'(last_acc), 1);
    chk("post_reset_stall", 32'(stalls), 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) drain_req = !drain_req;
      rst = $urandom_range(0, 199) != 0;
      pres($urandom_range(0, 9) < 8, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
           4'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
